// File: rtl/instr_enc.sv
// ALU request -> RV32I OP/OP-IMM instruction encoder with output FIFO.
// Optional emitted-instruction counter: define INSTR_ENC_CNT_EN.
module instr_enc #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_alu_ctrl,
    input  logic             i_use_imm,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [11:0]      i_imm,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_instr,
    output logic             o_err,
    output logic [CNT_W-1:0] o_instr_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OPC_R = 7'h33;
    localparam logic [6:0] OPC_I = 7'h13;
    localparam logic [6:0] F7_ALT = 7'h20;

    logic [2:0]  funct3;
    logic        known;
    logic        is_shift;
    logic        is_alt;
    logic        legal;
    logic [6:0]  hi7;
    logic [31:0] enc;

    always_comb begin
        funct3   = 3'b000;
        known    = 1'b1;
        is_shift = 1'b0;
        is_alt   = 1'b0;
        unique case (i_alu_ctrl)
            ALU_ADD:  funct3 = 3'b000;
            ALU_SUB: begin
                funct3 = 3'b000;
                is_alt = 1'b1;
            end
            ALU_SLL: begin
                funct3   = 3'b001;
                is_shift = 1'b1;
            end
            ALU_SLT:  funct3 = 3'b010;
            ALU_SLTU: funct3 = 3'b011;
            ALU_XOR:  funct3 = 3'b100;
            ALU_SRL: begin
                funct3   = 3'b101;
                is_shift = 1'b1;
            end
            ALU_SRA: begin
                funct3   = 3'b101;
                is_shift = 1'b1;
                is_alt   = 1'b1;
            end
            ALU_OR:   funct3 = 3'b110;
            ALU_AND:  funct3 = 3'b111;
            default:  known  = 1'b0;
        endcase
    end

    // No immediate form of SUB; shift immediates carry only a 5-bit shamt.
    always_comb begin
        legal = known;
        if (i_use_imm) begin
            if (i_alu_ctrl == ALU_SUB) begin
                legal = 1'b0;
            end
            if (is_shift && (|i_imm[11:5])) begin
                legal = 1'b0;
            end
        end
    end

    always_comb begin
        hi7 = is_alt ? F7_ALT : 7'h00;
        enc = '0;
        if (!i_use_imm) begin
            enc = {hi7, i_rs2, i_rs1, funct3, i_rd, OPC_R};
        end else if (is_shift) begin
            enc = {hi7, i_imm[4:0], i_rs1, funct3, i_rd, OPC_I};
        end else begin
            enc = {i_imm, i_rs1, funct3, i_rd, OPC_I};
        end
    end

    logic          rdy_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [31:0]   mem_q [DEPTH];
    logic          err_q;
    logic          accept;
    logic          push;
    logic          pop;

    assign o_ready = rdy_q && (count_q < CW'(DEPTH));
    assign o_valid = (count_q != '0);
    assign accept  = i_valid && o_ready;
    assign push    = accept && legal;
    assign pop     = o_valid && i_ready;
    assign o_instr = mem_q[rd_ptr_q];
    assign o_err   = err_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rdy_q   <= 1'b1;
            count_q <= count_d;
            err_q   <= accept && !legal;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= enc;
        end
    end

`ifdef INSTR_ENC_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_instr_cnt = cnt_q;
`else
    assign o_instr_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: vector table, directed
// sequences and randomized traffic against a queue model.
module tb_instr_enc;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SLL  = 4'b0001;
    localparam logic [3:0] C_SLT  = 4'b0010;
    localparam logic [3:0] C_SLTU = 4'b0011;
    localparam logic [3:0] C_XOR  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_OR   = 4'b0110;
    localparam logic [3:0] C_AND  = 4'b0111;
    localparam logic [3:0] C_SUB  = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1101;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_alu_ctrl;
    logic             i_use_imm;
    logic [4:0]       i_rd;
    logic [4:0]       i_rs1;
    logic [4:0]       i_rs2;
    logic [11:0]      i_imm;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_instr;
    logic             o_err;
    logic [CNT_W-1:0] o_instr_cnt;

    instr_enc #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_alu_ctrl  (i_alu_ctrl),
        .i_use_imm   (i_use_imm),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_imm       (i_imm),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_instr     (o_instr),
        .o_err       (o_err),
        .o_instr_cnt (o_instr_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: field values placed with plain arithmetic.
    function automatic void model(
        input  logic [3:0]  c,
        input  logic        im,
        input  logic [4:0]  rd,
        input  logic [4:0]  rs1,
        input  logic [4:0]  rs2,
        input  logic [11:0] imm,
        output bit          ok,
        output int unsigned w
    );
        int unsigned f3 = 0;
        bit known = 1, shift = 0, alt = 0;
        int unsigned base;
        case (c)
            C_ADD:  f3 = 0;
            C_SUB:  begin f3 = 0; alt = 1; end
            C_SLL:  begin f3 = 1; shift = 1; end
            C_SLT:  f3 = 2;
            C_SLTU: f3 = 3;
            C_XOR:  f3 = 4;
            C_SRL:  begin f3 = 5; shift = 1; end
            C_SRA:  begin f3 = 5; shift = 1; alt = 1; end
            C_OR:   f3 = 6;
            C_AND:  f3 = 7;
            default: known = 0;
        endcase
        ok = known && !(im && c == C_SUB) && !(im && shift && imm >= 32);
        base = rd * 128 + f3 * 4096 + rs1 * 32768;
        if (!im)
            w = base + 'h33 + rs2 * (1 << 20) + (alt ? 32'h4000_0000 : 0);
        else if (shift)
            w = base + 'h13 + (imm % 32) * (1 << 20) + (alt ? 32'h4000_0000 : 0);
        else
            w = base + 'h13 + imm * (1 << 20);
    endfunction

    // Queue model of the output stream, evaluated away from the clock edge.
    bit          mon_en = 0;
    int unsigned mq[$];
    bit          err_exp = 0;
    int unsigned cnt_exp = 0;

    always @(negedge i_clk) begin
        if (mon_en) begin
            bit ok, rdy;
            int unsigned w;
            chk("m_ready", o_ready, mq.size() < DEPTH);
            chk("m_valid", o_valid, mq.size() != 0);
            if (mq.size() != 0) chk("m_head", o_instr, mq[0]);
            chk("m_err", o_err, err_exp);
`ifdef INSTR_ENC_CNT_EN
            chk("m_cnt", o_instr_cnt, cnt_exp % 16);
`else
            chk("m_cnt", o_instr_cnt, 0);
`endif
            rdy = mq.size() < DEPTH;
            model(i_alu_ctrl, i_use_imm, i_rd, i_rs1, i_rs2, i_imm, ok, w);
            if (mq.size() != 0 && i_ready) begin
                void'(mq.pop_front());
                cnt_exp++;
            end
            err_exp = i_valid && rdy && !ok;
            if (i_valid && rdy && ok) mq.push_back(w);
        end
    end

    typedef struct {
        logic [3:0]  c;
        logic        im;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[14];

    task automatic drive(vec_t v);
        i_alu_ctrl = v.c;
        i_use_imm  = v.im;
        i_rd       = v.rd;
        i_rs1      = v.rs1;
        i_rs2      = v.rs2;
        i_imm      = v.imm;
        i_valid    = 1'b1;
    endtask

    // Entered and left at posedge+2.
    task automatic apply(vec_t v);
        i_ready = 1'b1;
        drive(v);
        @(posedge i_clk);
        #1;
        if (v.err) begin
            chk("t_err", o_err, 1);
            chk("t_novalid", o_valid, 0);
        end else begin
            chk("t_valid", o_valid, 1);
            chk("t_instr", o_instr, v.exp);
            chk("t_noerr", o_err, 0);
        end
        #1 i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        chk("t_drain", o_valid, 0);
        chk("t_err1", o_err, 0);
        #1;
    endtask

    task automatic rst_seq();
        mon_en = 0;
        i_rst_n = 1'b0;
        #1;
        chk("r_valid", o_valid, 0);
        chk("r_instr", o_instr, 0);
        chk("r_err", o_err, 0);
        chk("r_cnt", o_instr_cnt, 0);
        mq.delete();
        err_exp = 0;
        cnt_exp = 0;
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1 chk("r_ready", o_ready, 1);
        #1 mon_en = 1;
    endtask

    function automatic vec_t mk(logic [3:0] c, logic im, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2,
                                logic [11:0] imm);
        vec_t v;
        bit ok;
        int unsigned w;
        model(c, im, rd, rs1, rs2, imm, ok, w);
        v = '{c, im, rd, rs1, rs2, imm, !ok, w};
        return v;
    endfunction

    initial begin
        vec_t a, b, cc;
        tv[0]  = '{C_ADD,  0, 1,  2,  3,  12'h000, 0, 32'h003100B3};
        tv[1]  = '{C_SUB,  0, 5,  6,  7,  12'h000, 0, 32'h407302B3};
        tv[2]  = '{C_ADD,  1, 1,  0,  0,  12'hFFF, 0, 32'hFFF00093};
        tv[3]  = '{C_SRA,  1, 2,  3,  0,  12'h004, 0, 32'h4041D113};
        tv[4]  = '{C_SLL,  1, 2,  3,  0,  12'h020, 1, 32'h0};
        tv[5]  = '{4'hF,   0, 1,  1,  1,  12'h000, 1, 32'h0};
        tv[6]  = '{C_SUB,  1, 1,  1,  0,  12'h001, 1, 32'h0};
        tv[7]  = '{C_XOR,  0, 10, 11, 12, 12'h000, 0, 32'h00C5C533};
        tv[8]  = '{C_SRL,  1, 4,  5,  0,  12'h01F, 0, 32'h01F2D213};
        tv[9]  = '{C_SLTU, 1, 8,  9,  0,  12'h800, 0, 32'h8004B413};
        tv[10] = '{C_AND,  0, 31, 31, 31, 12'h000, 0, 32'h01FFFFB3};
        tv[11] = '{C_SRA,  0, 1,  1,  1,  12'h000, 0, 32'h4010D0B3};
        tv[12] = '{C_SLL,  1, 0,  0,  0,  12'h01F, 0, 32'h01F01013};
        tv[13] = '{4'hA,   0, 3,  3,  3,  12'h000, 1, 32'h0};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_alu_ctrl = '0;
        i_use_imm = 1'b0;
        i_rd = '0;
        i_rs1 = '0;
        i_rs2 = '0;
        i_imm = '0;
        @(posedge i_clk);
        #2;
        rst_seq();

        for (int i = 0; i < 14; i++) apply(tv[i]);

        // Back-to-back SUB then ADDI with continuous drain.
        i_ready = 1'b1;
        drive(tv[1]);
        @(posedge i_clk);
        #1 chk("bb_sub", o_instr, tv[1].exp);
        #1 drive(tv[2]);
        @(posedge i_clk);
        #1 chk("bb_addi", o_instr, tv[2].exp);
        chk("bb_valid", o_valid, 1);
        #1 i_valid = 1'b0;
        @(posedge i_clk);
        #1 chk("bb_empty", o_valid, 0);
        #1;

        // Backpressure: third request held off while full.
        a = tv[0];
        b = tv[7];
        cc = tv[10];
        i_ready = 1'b0;
        drive(a);
        @(posedge i_clk);
        #1 chk("bp_rdy1", o_ready, 1);
        #1 drive(b);
        @(posedge i_clk);
        #1 chk("bp_full", o_ready, 0);
        chk("bp_headA", o_instr, a.exp);
        #1 drive(cc);
        @(posedge i_clk);
        #1 chk("bp_hold", o_ready, 0);
        chk("bp_stable", o_instr, a.exp);
        #1 i_ready = 1'b1;
        @(posedge i_clk);
        #1 chk("bp_headB", o_instr, b.exp);
        chk("bp_rdy2", o_ready, 1);
        #2;
        @(posedge i_clk);
        #1 chk("bp_headC", o_instr, cc.exp);
        #1 i_valid = 1'b0;
        @(posedge i_clk);
        #1 chk("bp_empty", o_valid, 0);
        #1;

        // Reset while two entries are pending.
        i_ready = 1'b0;
        drive(a);
        @(posedge i_clk);
        #2 drive(b);
        @(posedge i_clk);
        #2 i_valid = 1'b0;
        chk("mr_full", o_ready, 0);
        rst_seq();
        apply(tv[0]);

        // Counter wrap: 17 legal emits and one illegal request.
        rst_seq();
        for (int i = 0; i < 18; i++) begin
            if (i == 9) apply(tv[5]);
            else apply(mk(C_ADD, 1, 5'(i), 5'(i + 1), 0, 12'(i * 7)));
        end
`ifdef INSTR_ENC_CNT_EN
        chk("cnt_wrap", o_instr_cnt, 1);
`else
        chk("cnt_zero", o_instr_cnt, 0);
`endif

        // Randomized traffic against the queue model.
        for (int n = 0; n < 800; n++) begin
            i_valid    = ($urandom % 2) != 0;
            i_ready    = ($urandom % 4) != 0;
            i_alu_ctrl = 4'($urandom);
            i_use_imm  = ($urandom % 2) != 0;
            i_rd       = 5'($urandom);
            i_rs1      = 5'($urandom);
            i_rs2      = 5'($urandom);
            i_imm      = ($urandom % 2) != 0 ? 12'($urandom % 32)
                                             : 12'($urandom);
            @(posedge i_clk);
            #2;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1 chk("end_empty", o_valid, 0);
        #1 mon_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
